// File: rtl/unidade_controle_param_pkg.sv
// Shared definitions for the memory-sequence game control unit: state codes
// (also shown on the datapath debug display) and small decode helpers.
package unidade_controle_param_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL          = 4'h0,
    ST_INICIALIZA       = 4'h1,
    ST_INICIA_SEQUENCIA = 4'h2,
    ST_ESPERA           = 4'h3,
    ST_REGISTRA         = 4'h4,
    ST_COMPARA          = 4'h5,
    ST_PROXIMA          = 4'h6,
    ST_FINAL_SEQUENCIA  = 4'h7,
    ST_PROX_SEQUENCIA   = 4'h8,
    ST_PERDE_VIDA       = 4'h9,
    ST_FINAL_ACERTO     = 4'hA,
    ST_FINAL_TIMEOUT    = 4'hC,
    ST_FINAL_ERRO       = 4'hE
  } estado_t;

  localparam logic [3:0] CODIGO_INVALIDO = 4'hF;

  // Game-over states: they hold until a new iniciar request.
  function automatic logic estado_final(estado_t e);
    return (e == ST_FINAL_ACERTO) || (e == ST_FINAL_TIMEOUT) || (e == ST_FINAL_ERRO);
  endfunction

endpackage

// File: rtl/unidade_controle_param_contador_m.sv
// Generic mod-M counter with synchronous clear; fim flags the terminal count.
module contador_m #(
  parameter int M = 16,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      if (q == W'(M - 1)) q <= '0;
      else                q <= q + W'(1);
    end
  end

  assign fim = (q == W'(M - 1));

endmodule

// File: rtl/unidade_controle_param.sv
// Control unit for the memory-sequence game: round sequencing, per-play
// timeout with a latched difficulty mode, and a lives system with retry.
module unidade_controle_param
  import unidade_controle_param_pkg::*;
#(
  parameter int N_ROUNDS     = 16,
  parameter int TIMEOUT      = 3000,
  parameter int TIMEOUT_HARD = 1000,
  parameter int MAX_LIVES    = 3,
  localparam int RW = $clog2(N_ROUNDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          jogada,
  input  logic          igual,
  input  logic          fimRodada,
  input  logic          modo,
  output logic          zeraC,
  output logic          contaC,
  output logic          zeraR,
  output logic          registraR,
  output logic [RW-1:0] rodada,
  output logic [3:0]    vidas,
  output logic          acertou,
  output logic          errou,
  output logic          errou_timeout,
  output logic          pronto,
  output logic [3:0]    db_estado
);

  localparam int TW = $clog2(TIMEOUT);

  estado_t        estado, proximo;
  logic           modo_hard;
  logic           zera_t, conta_t, fim_normal, fim_t;
  logic [TW-1:0]  conta_q;
  logic           ultima_vida, ultima_rodada;

  // Play timer: counts espera cycles, cleared whenever a new play window opens.
  assign zera_t  = (estado == ST_INICIAL) || (estado == ST_INICIALIZA) ||
                   (estado == ST_INICIA_SEQUENCIA) || (estado == ST_PROXIMA);
  assign conta_t = (estado == ST_ESPERA);

  contador_m #(.M(TIMEOUT), .W(TW)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_t),
    .conta (conta_t),
    .q     (conta_q),
    .fim   (fim_normal)
  );

  assign fim_t = (estado == ST_ESPERA) &&
                 (modo_hard ? (conta_q == TW'(TIMEOUT_HARD - 1)) : fim_normal);

  assign ultima_vida   = (vidas <= 4'd1);
  assign ultima_rodada = (rodada == RW'(N_ROUNDS - 1));

  // NOTE: asynchronous active-high reset lives in the sensitivity list so the
  // FSM returns to inicial immediately, without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= ST_INICIAL;
    else       estado <= proximo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rodada    <= '0;
      vidas     <= 4'(MAX_LIVES);
      modo_hard <= 1'b0;
    end else begin
      case (estado)
        ST_INICIALIZA: begin
          rodada    <= '0;
          vidas     <= 4'(MAX_LIVES);
          modo_hard <= modo;
        end
        ST_PROX_SEQUENCIA: if (!ultima_rodada) rodada <= rodada + RW'(1);
        ST_PERDE_VIDA:     if (!ultima_vida)   vidas  <= vidas - 4'd1;
        default: ;
      endcase
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    proximo = estado;
    case (estado)
      ST_INICIAL:          if (iniciar) proximo = ST_INICIALIZA;
      ST_INICIALIZA:       proximo = ST_INICIA_SEQUENCIA;
      ST_INICIA_SEQUENCIA: proximo = ST_ESPERA;
      ST_ESPERA: begin
        if (fim_t)       proximo = ultima_vida ? ST_FINAL_TIMEOUT : ST_PERDE_VIDA;
        else if (jogada) proximo = ST_REGISTRA;
      end
      ST_REGISTRA:         proximo = ST_COMPARA;
      ST_COMPARA: begin
        if (!igual)         proximo = ultima_vida ? ST_FINAL_ERRO : ST_PERDE_VIDA;
        else if (fimRodada) proximo = ST_FINAL_SEQUENCIA;
        else                proximo = ST_PROXIMA;
      end
      ST_PROXIMA:          proximo = ST_ESPERA;
      ST_FINAL_SEQUENCIA:  proximo = ultima_rodada ? ST_FINAL_ACERTO : ST_PROX_SEQUENCIA;
      ST_PROX_SEQUENCIA:   proximo = ST_INICIA_SEQUENCIA;
      ST_PERDE_VIDA:       proximo = ST_INICIA_SEQUENCIA;
      ST_FINAL_ACERTO, ST_FINAL_TIMEOUT, ST_FINAL_ERRO:
                           if (iniciar) proximo = ST_INICIALIZA;
      default:             proximo = ST_INICIAL;
    endcase
  end

  // Moore output decode.
  always_comb begin
    zeraC         = (estado == ST_INICIAL) || (estado == ST_INICIALIZA) ||
                    (estado == ST_INICIA_SEQUENCIA);
    zeraR         = (estado == ST_INICIAL) || (estado == ST_INICIALIZA);
    registraR     = (estado == ST_REGISTRA);
    contaC        = (estado == ST_PROXIMA);
    pronto        = estado_final(estado);
    errou         = (estado == ST_FINAL_ERRO) || (estado == ST_FINAL_TIMEOUT);
    errou_timeout = (estado == ST_FINAL_TIMEOUT);
    acertou       = (estado == ST_FINAL_ACERTO);
    case (estado)
      ST_INICIAL, ST_INICIALIZA, ST_INICIA_SEQUENCIA, ST_ESPERA, ST_REGISTRA,
      ST_COMPARA, ST_PROXIMA, ST_FINAL_SEQUENCIA, ST_PROX_SEQUENCIA,
      ST_PERDE_VIDA, ST_FINAL_ACERTO, ST_FINAL_TIMEOUT, ST_FINAL_ERRO:
               db_estado = estado;
      default: db_estado = CODIGO_INVALIDO;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_param.sv
// Self-checking bench: randomized plays scored against a play-level game model.
module tb_unidade_controle_param;

  localparam int N_ROUNDS     = 4;
  localparam int TIMEOUT      = 10;
  localparam int TIMEOUT_HARD = 5;
  localparam int MAX_LIVES    = 2;
  localparam int RW           = $clog2(N_ROUNDS);

  // State codes as documented for the debug display.
  localparam logic [3:0] C_INICIAL = 4'h0, C_INICIALIZA = 4'h1, C_INICIA = 4'h2,
                         C_ESPERA = 4'h3, C_REGISTRA = 4'h4, C_COMPARA = 4'h5,
                         C_PROXIMA = 4'h6, C_FIM_SEQ = 4'h7, C_PROX_SEQ = 4'h8,
                         C_PERDE = 4'h9, C_ACERTO = 4'hA, C_TIMEOUT = 4'hC,
                         C_ERRO = 4'hE;

  localparam int ACT_OK = 0, ACT_WRONG = 1, ACT_TIMEOUT = 2;

  logic          clock = 1'b0;
  logic          reset, iniciar, jogada, igual, fimRodada, modo;
  logic          zeraC, contaC, zeraR, registraR;
  logic [RW-1:0] rodada;
  logic [3:0]    vidas, db_estado;
  logic          acertou, errou, errou_timeout, pronto;

  unidade_controle_param #(
    .N_ROUNDS(N_ROUNDS), .TIMEOUT(TIMEOUT),
    .TIMEOUT_HARD(TIMEOUT_HARD), .MAX_LIVES(MAX_LIVES)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimRodada(fimRodada), .modo(modo),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .rodada(rodada), .vidas(vidas), .acertou(acertou), .errou(errou),
    .errou_timeout(errou_timeout), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Stand-in for the datapath address counter, driven by the unit's controls.
  int addr;
  always @(posedge clock or posedge reset) begin
    if (reset)       addr <= 0;
    else if (zeraC)  addr <= 0;
    else if (contaC) addr <= addr + 1;
  end

  int total = 0;
  int bad   = 0;

  // Model of the game as seen by a player.
  logic [3:0] cur;
  int m_rodada, m_vidas, m_limit, p;
  bit m_hard, game_over, probe_reset;
  int script[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // {zeraC, contaC, zeraR, registraR, acertou, errou, errou_timeout, pronto}
  function automatic logic [7:0] outs_for(input logic [3:0] c);
    logic [7:0] o;
    o[7] = (c == C_INICIAL) || (c == C_INICIALIZA) || (c == C_INICIA);
    o[6] = (c == C_PROXIMA);
    o[5] = (c == C_INICIAL) || (c == C_INICIALIZA);
    o[4] = (c == C_REGISTRA);
    o[3] = (c == C_ACERTO);
    o[2] = (c == C_ERRO) || (c == C_TIMEOUT);
    o[1] = (c == C_TIMEOUT);
    o[0] = (c == C_ACERTO) || (c == C_ERRO) || (c == C_TIMEOUT);
    return o;
  endfunction

  task automatic check_all();
    check("estado", db_estado, cur);
    check("saidas", {zeraC, contaC, zeraR, registraR, acertou, errou, errou_timeout, pronto},
          outs_for(cur));
    check("rodada", rodada, m_rodada);
    check("vidas", vidas, m_vidas);
  endtask

  // One clock: inputs that the current state ignores are randomized.
  task automatic tick(input logic [3:0] exp);
    if (!(cur inside {C_INICIAL, C_ACERTO, C_TIMEOUT, C_ERRO})) iniciar = 1'($urandom_range(0, 1));
    modo = (cur == C_INICIALIZA) ? m_hard : 1'($urandom_range(0, 1));
    if (cur != C_ESPERA) jogada = 1'($urandom_range(0, 1));
    if (!(cur inside {C_ESPERA, C_REGISTRA, C_COMPARA})) begin
      igual     = 1'($urandom_range(0, 1));
      fimRodada = 1'($urandom_range(0, 1));
    end
    @(posedge clock);
    #1;
    cur = exp;
    check_all();
  endtask

  task automatic lose(input logic [3:0] final_code);
    if (m_vidas > 1) begin
      tick(C_PERDE);
      m_vidas--;
      p = 0;
      tick(C_INICIA);
      tick(C_ESPERA);
    end else begin
      tick(final_code);
      game_over = 1;
    end
  endtask

  task automatic start_game(input bit hard);
    int hold;
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      iniciar = 1'b0;
      tick(cur);
    end
    iniciar = 1'b1;
    m_hard  = hard;
    tick(C_INICIALIZA);
    m_rodada  = 0;
    m_vidas   = MAX_LIVES;
    m_limit   = hard ? TIMEOUT_HARD : TIMEOUT;
    p         = 0;
    game_over = 0;
    tick(C_INICIA);
    tick(C_ESPERA);
  endtask

  task automatic do_play(input int act);
    int k;
    if (act == ACT_TIMEOUT) begin
      for (int i = 1; i < m_limit; i++) begin
        jogada = 1'b0;
        tick(C_ESPERA);
      end
      // A play landing on the last allowed cycle still loses to the timeout.
      jogada = 1'($urandom_range(0, 1));
      lose(C_TIMEOUT);
    end else begin
      k = $urandom_range(1, m_limit - 1);
      for (int i = 1; i < k; i++) begin
        jogada = 1'b0;
        tick(C_ESPERA);
      end
      jogada    = 1'b1;
      igual     = (act == ACT_OK);
      fimRodada = (p == m_rodada);
      tick(C_REGISTRA);
      check("endereco", addr, p);
      tick(C_COMPARA);
      if (probe_reset && m_rodada == 2) begin
        #2 reset = 1'b1;
        #1;
        cur = C_INICIAL;
        m_rodada = 0;
        m_vidas  = MAX_LIVES;
        check_all();
        @(negedge clock);
        reset     = 1'b0;
        iniciar   = 1'b0;
        game_over = 1;
        probe_reset = 0;
      end else if (act != ACT_OK) begin
        lose(C_ERRO);
      end else if (p == m_rodada) begin
        tick(C_FIM_SEQ);
        if (m_rodada == N_ROUNDS - 1) begin
          tick(C_ACERTO);
          game_over = 1;
        end else begin
          tick(C_PROX_SEQ);
          m_rodada++;
          p = 0;
          tick(C_INICIA);
          tick(C_ESPERA);
        end
      end else begin
        p++;
        tick(C_PROXIMA);
        tick(C_ESPERA);
      end
    end
  endtask

  task automatic run_game(input bit hard);
    int r, act;
    start_game(hard);
    while (!game_over) begin
      if (script.size() > 0) begin
        act = script.pop_front();
      end else begin
        r   = $urandom_range(0, 19);
        act = (r < 14) ? ACT_OK : (r < 17) ? ACT_WRONG : ACT_TIMEOUT;
      end
      do_play(act);
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
    fimRodada = 1'b0; modo = 1'b0; probe_reset = 0;
    cur = C_INICIAL; m_rodada = 0; m_vidas = MAX_LIVES; m_hard = 0;
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iniciar = 1'b0;
      tick(C_INICIAL);
    end

    // Clean win in normal mode.
    for (int i = 0; i < 10; i++) script.push_back(ACT_OK);
    run_game(1'b0);

    // Wrong play in round 1 costs a life, a second wrong play ends the game.
    script = '{ACT_OK, ACT_OK, ACT_WRONG, ACT_WRONG};
    run_game(1'b0);

    // Two timeouts, normal then hard limit; restart from final_erro first.
    script = '{ACT_TIMEOUT, ACT_TIMEOUT};
    run_game(1'b0);
    script = '{ACT_OK, ACT_TIMEOUT, ACT_TIMEOUT};
    run_game(1'b1);

    // Asynchronous reset while comparing in round 2.
    for (int i = 0; i < 4; i++) script.push_back(ACT_OK);
    probe_reset = 1;
    run_game(1'b0);

    for (int g = 0; g < 16; g++) run_game(1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
